// File: rtl/ysyx_040750_hazard_fwd_unit_pkg.sv
// Shared definitions for the hazard/forwarding unit: tag entry layout and stage indices.
package ysyx_040750_hazard_fwd_unit_pkg;

    localparam int unsigned REG_AW = 5;

    // Tag entry layout, MSB first: {v, wen, is_load, rd}
    localparam int unsigned TAG_W        = REG_AW + 3;
    localparam int unsigned TAG_RD_LSB   = 0;
    localparam int unsigned TAG_LOAD_BIT = REG_AW;
    localparam int unsigned TAG_WEN_BIT  = REG_AW + 1;
    localparam int unsigned TAG_V_BIT    = REG_AW + 2;

    localparam int unsigned STG_EX  = 0;
    localparam int unsigned STG_MEM = 1;
    localparam int unsigned STG_WB  = 2;

    typedef struct packed {
        logic              v;
        logic              wen;
        logic              is_load;
        logic [REG_AW-1:0] rd;
    } tag_t;

    // A producer matches only if it really writes a nonzero rd that this source really reads.
    function automatic logic tag_match(input tag_t t, input logic [REG_AW-1:0] addr, input logic used);
        return t.v & t.wen & (t.rd == addr) & (t.rd != '0) & used;
    endfunction

endpackage

// File: rtl/ysyx_040750_fwd_select.sv
// Priority match and operand mux for one source: youngest matching stage wins.
module ysyx_040750_fwd_select
    import ysyx_040750_hazard_fwd_unit_pkg::*;
#(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned NSTAGE   = 3,
    parameter int unsigned LOAD_RDY = 1
) (
    input  tag_t [NSTAGE-1:0]      tags,
    input  logic [REG_AW-1:0]      rs_addr,
    input  logic                   rs_used,
    input  logic [XLEN-1:0]        rs_data,
    input  logic [NSTAGE*XLEN-1:0] stage_data,
    output logic [XLEN-1:0]        fwd_data,
    output logic [NSTAGE-1:0]      hit,
    output logic                   not_ready
);

    logic found;

    // Once the youngest match is found, older ones are ignored even if they are ready.
    always_comb begin
        fwd_data  = rs_data;
        hit       = '0;
        not_ready = 1'b0;
        found     = 1'b0;
        for (int k = 0; k < int'(NSTAGE); k++) begin
            if (!found && tag_match(tags[k], rs_addr, rs_used)) begin
                found = 1'b1;
                if (!tags[k].is_load || (k >= int'(LOAD_RDY))) begin
                    fwd_data = stage_data[XLEN*k +: XLEN];
                    hit[k]   = 1'b1;
                end else begin
                    not_ready = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ysyx_040750_hazard_fwd_unit.sv
// Operand forwarding and load-use stall detection beside the ID/EX boundary.
// Keeps a tag pipeline shadowing EX..WB, advanced by the pipeline-advance strobe.
module ysyx_040750_hazard_fwd_unit
    import ysyx_040750_hazard_fwd_unit_pkg::*;
#(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned NSTAGE   = 3,
    parameter int unsigned NSRC     = 2,
    parameter int unsigned LOAD_RDY = 1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                     I_clk,
    input  logic                     I_rst,
    input  logic                     I_pipe_adv,
    input  logic                     I_flush,
    input  logic                     I_id_valid,
    input  logic [REG_AW-1:0]        I_id_rd,
    input  logic                     I_id_wen,
    input  logic                     I_id_is_load,
    input  logic [NSRC*REG_AW-1:0]   I_rs_addr,
    input  logic [NSRC-1:0]          I_rs_used,
    input  logic [NSRC*XLEN-1:0]     I_rs_data,
    input  logic [NSTAGE*XLEN-1:0]   I_stage_data,
    output logic [NSRC*XLEN-1:0]     O_rs_data,
    output logic [NSRC*NSTAGE-1:0]   O_fwd_hit,
    output logic                     O_stall,
    output logic [CNT_W-1:0]         O_stall_cnt
);

    tag_t [NSTAGE-1:0] tags;
    logic [NSRC-1:0]   src_stall;

    for (genvar s = 0; s < int'(NSRC); s++) begin : g_src
        ysyx_040750_fwd_select #(
            .XLEN     (XLEN),
            .NSTAGE   (NSTAGE),
            .LOAD_RDY (LOAD_RDY)
        ) u_sel (
            .tags       (tags),
            .rs_addr    (I_rs_addr[REG_AW*s +: REG_AW]),
            .rs_used    (I_rs_used[s]),
            .rs_data    (I_rs_data[XLEN*s +: XLEN]),
            .stage_data (I_stage_data),
            .fwd_data   (O_rs_data[XLEN*s +: XLEN]),
            .hit        (O_fwd_hit[NSTAGE*s +: NSTAGE]),
            .not_ready  (src_stall[s])
        );
    end

    assign O_stall = I_id_valid & (|src_stall);

    // Stalled or flushed issue enters EX as a bubble; a flush without advance kills EX in place.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            tags <= '0;
        end else if (I_pipe_adv) begin
            for (int k = 1; k < int'(NSTAGE); k++) begin
                tags[k] <= tags[k-1];
            end
            tags[0] <= '{v:       I_id_valid & ~O_stall & ~I_flush,
                         wen:     I_id_wen,
                         is_load: I_id_is_load,
                         rd:      I_id_rd};
        end else if (I_flush) begin
            tags[0] <= '0;
        end
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            O_stall_cnt <= '0;
        end else if (O_stall && I_pipe_adv && !(&O_stall_cnt)) begin
            O_stall_cnt <= O_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ysyx_040750_hazard_fwd_unit.sv
// Directed scoreboard bench for the hazard/forwarding unit (counter width reduced to 3).
module tb_ysyx_040750_hazard_fwd_unit;
    import ysyx_040750_hazard_fwd_unit_pkg::*;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned NSTAGE = 3;
    localparam int unsigned NSRC   = 2;
    localparam int unsigned CNT_W  = 3;

    localparam logic [63:0] RF0   = 64'hAAAA_AAAA_0000_0000;
    localparam logic [63:0] RF1   = 64'hBBBB_BBBB_0000_0000;
    localparam logic [63:0] D_EX  = 64'h1111_1111_1111_1111;
    localparam logic [63:0] D_MEM = 64'h2222_2222_2222_2222;
    localparam logic [63:0] D_WB  = 64'h3333_3333_3333_3333;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     pipe_adv, flush, id_valid, id_wen, id_is_load;
    logic [REG_AW-1:0]        id_rd;
    logic [NSRC*REG_AW-1:0]   rs_addr;
    logic [NSRC-1:0]          rs_used;
    logic [NSRC*XLEN-1:0]     rs_data_in;
    logic [NSTAGE*XLEN-1:0]   stage_data;
    logic [NSRC*XLEN-1:0]     rs_data_out;
    logic [NSRC*NSTAGE-1:0]   fwd_hit;
    logic                     stall;
    logic [CNT_W-1:0]         stall_cnt;

    ysyx_040750_hazard_fwd_unit #(
        .XLEN(XLEN), .NSTAGE(NSTAGE), .NSRC(NSRC), .LOAD_RDY(1), .CNT_W(CNT_W)
    ) dut (
        .I_clk        (clk),
        .I_rst        (rst),
        .I_pipe_adv   (pipe_adv),
        .I_flush      (flush),
        .I_id_valid   (id_valid),
        .I_id_rd      (id_rd),
        .I_id_wen     (id_wen),
        .I_id_is_load (id_is_load),
        .I_rs_addr    (rs_addr),
        .I_rs_used    (rs_used),
        .I_rs_data    (rs_data_in),
        .I_stage_data (stage_data),
        .O_rs_data    (rs_data_out),
        .O_fwd_hit    (fwd_hit),
        .O_stall      (stall),
        .O_stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [63:0]      d0;
        logic [63:0]      d1;
        logic [5:0]       hit;
        logic             stall;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    function automatic logic [5:0] hb(input int unsigned s, input int unsigned k);
        return 6'(1) << (s * NSTAGE + k);
    endfunction

    task automatic chk(input string name, input string field, input logic [63:0] act, input logic [63:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s.%s: got %h, expected %h", name, field, act, want);
        end
    endtask

    // Monitor: outputs are settled by the falling edge of every cycle that carries an expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.name, "rs0",   rs_data_out[63:0],   e.d0);
            chk(e.name, "rs1",   rs_data_out[127:64], e.d1);
            chk(e.name, "hit",   64'(fwd_hit),        64'(e.hit));
            chk(e.name, "stall", 64'(stall),          64'(e.stall));
            chk(e.name, "cnt",   64'(stall_cnt),      64'(e.cnt));
        end
    end

    task automatic step(input string name, input logic adv, input logic fl, input logic idv,
                        input logic [4:0] rd, input logic wen, input logic ld,
                        input logic [4:0] a0, input logic u0, input logic [4:0] a1, input logic u1,
                        input logic [63:0] e0, input logic [63:0] e1, input logic [5:0] eh,
                        input logic es, input logic [CNT_W-1:0] ec, input logic do_rst = 1'b0);
        exp_t e;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        pipe_adv   = adv;
        flush      = fl;
        id_valid   = idv;
        id_rd      = rd;
        id_wen     = wen;
        id_is_load = ld;
        rs_addr    = {a1, a0};
        rs_used    = {u1, u0};
        if (do_rst) begin
            #1;
            rst = 1'b1;
        end
        e.name = name; e.d0 = e0; e.d1 = e1; e.hit = eh; e.stall = es; e.cnt = ec;
        exp_q.push_back(e);
    endtask

    initial begin
        rst        = 1'b1;
        pipe_adv   = 1'b0;
        flush      = 1'b0;
        id_valid   = 1'b0;
        id_rd      = '0;
        id_wen     = 1'b0;
        id_is_load = 1'b0;
        rs_addr    = '0;
        rs_used    = '0;
        rs_data_in = {RF1, RF0};
        stage_data = {D_WB, D_MEM, D_EX};
        repeat (2) @(posedge clk);

        //    name                 adv fl v  rd wen ld a0 u0 a1 u1  d0     d1     hit                               st cnt
        step("reset_idle",         0, 0, 1, 0, 0, 0, 5, 1, 0, 0, RF0,   RF1,   6'd0,                              0, 0);
        step("issue_add_x5",       1, 0, 1, 5, 1, 0, 1, 1, 0, 0, RF0,   RF1,   6'd0,                              0, 0);
        step("fwd_ex",             1, 0, 1, 0, 0, 0, 5, 1, 0, 0, D_EX,  RF1,   hb(0, STG_EX),                     0, 0);
        step("fwd_mem",            1, 0, 1, 0, 0, 0, 5, 1, 0, 0, D_MEM, RF1,   hb(0, STG_MEM),                    0, 0);
        step("fwd_wb",             1, 0, 1, 0, 0, 0, 5, 1, 0, 0, D_WB,  RF1,   hb(0, STG_WB),                     0, 0);
        step("no_fwd_issue_ld7",   1, 0, 1, 7, 1, 1, 5, 1, 0, 0, RF0,   RF1,   6'd0,                              0, 0);
        step("load_use_stall",     1, 0, 1, 8, 1, 0, 0, 0, 7, 1, RF0,   RF1,   6'd0,                              1, 0);
        step("load_fwd_mem",       1, 0, 1, 8, 1, 0, 0, 0, 7, 1, RF0,   D_MEM, hb(1, STG_MEM),                    0, 1);
        step("both_srcs",          1, 0, 1, 5, 1, 0, 8, 1, 7, 1, D_EX,  D_WB,  hb(0, STG_EX) | hb(1, STG_WB),     0, 1);
        step("x0_src_mem",         1, 0, 1, 6, 1, 0, 0, 1, 8, 1, RF0,   D_MEM, hb(1, STG_MEM),                    0, 1);
        step("split_stages",       1, 0, 1, 5, 1, 0, 5, 1, 6, 1, D_MEM, D_EX,  hb(0, STG_MEM) | hb(1, STG_EX),    0, 1);
        step("ex_beats_wb",        1, 0, 1, 0, 1, 0, 5, 1, 0, 1, D_EX,  RF1,   hb(0, STG_EX),                     0, 1);
        step("x0_write_ignored",   1, 0, 1, 7, 1, 1, 0, 1, 0, 1, RF0,   RF1,   6'd0,                              0, 1);
        for (int i = 0; i < 3; i++)
            step($sformatf("hold_stall_%0d", i),
                                   0, 0, 1, 8, 1, 0, 7, 1, 0, 0, RF0,   RF1,   6'd0,                              1, 1);
        step("flush_no_adv",       0, 1, 1, 8, 1, 0, 7, 1, 0, 0, RF0,   RF1,   6'd0,                              1, 1);
        step("stall_dropped",      0, 0, 1, 8, 1, 0, 7, 1, 0, 0, RF0,   RF1,   6'd0,                              0, 1);
        step("reissue_ld7",        1, 0, 1, 7, 1, 1, 0, 0, 0, 0, RF0,   RF1,   6'd0,                              0, 1);

        // Alternating stall / forward pairs walk the 3-bit counter into saturation.
        for (int i = 0; i < 8; i++) begin
            int sb, sa;
            sb = (1 + i > 7) ? 7 : 1 + i;
            sa = (2 + i > 7) ? 7 : 2 + i;
            step($sformatf("sat_stall_%0d", i),
                                   1, 0, 1, 8, 1, 0, 7, 1, 0, 0, RF0,   RF1,   6'd0,                              1, CNT_W'(sb));
            step($sformatf("sat_fwd_%0d", i),
                                   1, 0, 1, 7, 1, 1, 7, 1, 0, 0, D_MEM, RF1,   hb(0, STG_MEM),                    0, CNT_W'(sa));
        end

        step("async_reset",        0, 0, 1, 8, 1, 0, 7, 1, 7, 1, RF0,   RF1,   6'd0,                              0, 0, 1'b1);
        step("post_reset",         1, 0, 1, 8, 1, 0, 7, 1, 7, 1, RF0,   RF1,   6'd0,                              0, 0);

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ysyx_040750_hazard_fwd_unit.md
Name: ysyx_040750_hazard_fwd_unit

Overview:
- Parametrised successor to the combinational forwarding mux.
- Owns a tag pipeline (valid/wen/rd/is_load) that shadows the EX..WB stage registers, advanced by the pipeline-advance strobe.
- Forwards the youngest ready in-flight result to each ID source operand, and raises a load-use stall when the matching producer's data is not yet available.
- Sits beside the ID/EX boundary. Driven by ID decode, stage result buses and the global advance/flush controls.

Parameters:
- XLEN, 64, datapath width.
- NSTAGE, 3, tracked stages after ID (index 0=EX, 1=MEM, 2=WB).
- NSRC, 2, source operands per instruction.
- LOAD_RDY, 1, first stage index at which a load result is valid.
- CNT_W, 32, stall-counter width.

Ports:
- I_clk  in  1  clock
- I_rst  in  1  asynchronous active-high reset
- I_pipe_adv  in  1  whole pipeline advances this cycle
- I_flush  in  1  kill EX-entry and ID issue (branch redirect)
- I_id_valid  in  1  ID holds a valid instruction
- I_id_rd  in  5  ID destination register
- I_id_wen  in  1  ID writes rd
- I_id_is_load  in  1  ID instruction is a load
- I_rs_addr  in  NSRC*5  source addresses; src s at [5s+:5]
- I_rs_used  in  NSRC  source s is actually read
- I_rs_data  in  NSRC*XLEN  regfile read data
- I_stage_data  in  NSTAGE*XLEN  result at output of stage k, at [XLEN*k+:XLEN]
- O_rs_data  out  NSRC*XLEN  forwarded operands
- O_fwd_hit  out  NSRC*NSTAGE  one-hot forwarding source per operand, for debug/coverage
- O_stall  out  1  load-use hazard; hold PC/IF/ID, insert bubble
- O_stall_cnt  out  CNT_W  saturating count of cycles with O_stall & I_pipe_adv

Behaviour:
- Clock and reset: single clock I_clk. I_rst is asynchronous, active-high. On reset:
  - all tag entries v=0, wen=0, rd=0, is_load=0
  - O_stall_cnt=0
  - consequently O_stall=0, O_fwd_hit=0, O_rs_data=I_rs_data.
- Tag pipeline, updated on posedge when I_pipe_adv=1:
  - entry[k] <= entry[k-1] for k>=1.
  - entry[0] <= {I_id_valid & ~O_stall & ~I_flush, I_id_wen, I_id_rd, I_id_is_load}.
  - A stalled or flushed cycle loads a bubble (v=0).
- Tag pipeline with I_pipe_adv=0: all entries hold (memory back-pressure). O_stall stays combinationally valid.
- I_flush with I_pipe_adv=1: entry[0] becomes a bubble. Entries >=1 shift normally.
- I_flush with I_pipe_adv=0: entry[0] cleared, others held.
- Match for source s: entry k matches iff
  - v & wen & (rd == rs_addr_s) & (rd != 0) & I_rs_used[s].
  - x0 is never forwarded or stalled on.
- Priority: the lowest matching k (youngest) wins, exactly like an EX>MEM>WB chain.
- ready(k) = ~is_load | (k >= LOAD_RDY).
- Winning match that is ready:
  - O_rs_data[s] = I_stage_data[k]
  - O_fwd_hit[s*NSTAGE+k] = 1
- Winning match that is not ready: O_stall=1. Data output is don't-care; drive the regfile value. Older ready matches are NOT used.
- No match: O_rs_data[s] = I_rs_data[s] and the hit bits are 0.
- O_stall = OR over sources of (winning match not ready), gated by I_id_valid.
- Latency: forwarding and stall are combinational, zero-cycle. Tags have one-cycle update latency.
- Back-to-back load-use: one bubble. Next adv moves the load to MEM (ready), so the stall drops and MEM forwarding is used.
- Both sources hitting different stages: each operand is resolved independently.
- O_stall_cnt: +1 per cycle with O_stall & I_pipe_adv; saturates at all-ones.
- Reset mid-operation: all in-flight tags are dropped immediately (asynchronous). Forwarding reverts to regfile data in the same cycle.

Decomposition:
- Shared package/header holds:
  - tag entry field widths and offsets (REG_AW=5, entry layout {v,wen,is_load,rd})
  - stage index constants EX=0, MEM=1, WB=2.
- One natural sub-module: ysyx_040750_fwd_select.
  - Purely combinational priority match and mux for a single source.
  - Instantiated NSRC times via generate.
- The tag pipeline, stall OR and counter live in the top.

Test Plan:
- Reset, then ID rs1=5 used with no in-flight writers: O_rs_data[0]=I_rs_data[0], O_stall=0, O_fwd_hit=0.
- ALU add x5 issued, one adv; next ID reads x5: O_rs_data[0]=I_stage_data[EX], hit bit 0 set. After two more advs: hit moves to MEM, then WB, then none.
- Load x7, adv; ID add reads x7:
  - O_stall=1, stall count increments.
  - Next adv inserts a bubble; load reaches MEM, O_stall=0, forward from MEM.
- x5 written in EX and WB simultaneously: EX value wins. Write to x0 with rs1=0: no hit, regfile data passes through.
- Load-use stall with I_pipe_adv=0 for 3 cycles: tags hold, O_stall stays 1, counter unchanged. I_flush then clears EX, and the stall drops the same cycle.
- Assert I_rst asynchronously mid-stream with entries live: all outputs revert to reset values before the next clock edge. Also check the counter saturates at 2^CNT_W-1 with a reduced CNT_W=3.
